// File: rtl/fp_to_int.sv
// fp_to_int: multi-cycle IEEE-754 single to integer converter, truncating toward zero with saturation
module fp_to_int #(
  parameter int INT_WIDTH    = 32,
  parameter bit INT_UNSIGNED = 1'b1,
  parameter int FP_WIDTH     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [FP_WIDTH-1:0]  in,
  input  logic                 ready,
  output logic [INT_WIDTH-1:0] out,
  output logic                 valid,
  output logic                 sat
);
  localparam int MW = (INT_WIDTH > 24 ? INT_WIDTH : 24) + 1;
  localparam logic [1:0] IDLE = 2'd0, UNPACK = 2'd1, ALIGN = 2'd2, PACK = 2'd3;
  localparam logic signed [9:0] EW  = 10'(INT_WIDTH);
  localparam logic signed [9:0] EW1 = 10'(INT_WIDTH - 1);
  localparam logic signed [9:0] E23 = 10'sd23;
  localparam logic [INT_WIDTH-1:0] SMIN = {1'b1, {(INT_WIDTH-1){1'b0}}};
  localparam logic [INT_WIDTH-1:0] MAXV = INT_UNSIGNED ? '1 : ~SMIN;
  localparam logic [INT_WIDTH-1:0] MINV = INT_UNSIGNED ? '0 : SMIN;
  if (FP_WIDTH != 32) begin : g_fp_chk
    $error("fp_to_int: only FP_WIDTH=32 is supported");
  end
  if (INT_WIDTH < 8 || INT_WIDTH > 64) begin : g_int_chk
    $error("fp_to_int: INT_WIDTH must be within 8..64");
  end
  logic [1:0]           state;
  logic [31:0]          in_r;
  logic                 s_r, nan_r, inf_r, zero_r;
  logic signed [9:0]    e_r;
  logic [22:0]          m_r;
  logic [MW-1:0]        mag, mext;
  logic [INT_WIDTH-1:0] trunc, res;
  logic                 res_sat;
  assign mext  = {{(MW-24){1'b0}}, 1'b1, m_r};
  assign trunc = mag[INT_WIDTH-1:0];
  // result selection for PACK, in rule priority order (NaN, Inf, small, sign, range)
  always_comb begin
    res = s_r ? -trunc : trunc;
    res_sat = 1'b0;
    if (nan_r) begin
      res = '0;
      res_sat = 1'b1;
    end else if (inf_r) begin
      res = s_r ? MINV : MAXV;
      res_sat = 1'b1;
    end else if (zero_r) begin
      res = '0;
    end else if (INT_UNSIGNED && s_r) begin
      res = '0;
      res_sat = 1'b1;
    end else if (INT_UNSIGNED && e_r >= EW) begin
      res = MAXV;
      res_sat = 1'b1;
    end else if (!INT_UNSIGNED && !s_r && e_r >= EW1) begin
      res = MAXV;
      res_sat = 1'b1;
    end else if (!INT_UNSIGNED && s_r && (e_r > EW1 || (e_r == EW1 && trunc != SMIN))) begin
      res = MINV;
      res_sat = 1'b1;
    end
  end
  // four-state conversion sequencer with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      in_r   <= '0;
      s_r    <= 1'b0;
      nan_r  <= 1'b0;
      inf_r  <= 1'b0;
      zero_r <= 1'b0;
      e_r    <= '0;
      m_r    <= '0;
      mag    <= '0;
      out    <= '0;
      valid  <= 1'b0;
      sat    <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: if (ready) begin
          in_r  <= 32'(in);
          state <= UNPACK;
        end
        UNPACK: begin
          s_r    <= in_r[31];
          e_r    <= $signed({2'b00, in_r[30:23]}) - 10'sd127;
          m_r    <= in_r[22:0];
          nan_r  <= &in_r[30:23] && |in_r[22:0];
          inf_r  <= &in_r[30:23] && ~|in_r[22:0];
          zero_r <= in_r[30:23] < 8'd127;
          state  <= ALIGN;
        end
        ALIGN: begin
          mag   <= (e_r >= E23) ? mext << (e_r - E23) : mext >> (E23 - e_r);
          state <= PACK;
        end
        default: begin
          out   <= res;
          sat   <= res_sat;
          valid <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fp_to_int.sv
// tb_fp_to_int: table, randomized and sequence checks of fp_to_int in three configurations
module tb_fp_to_int;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ready = 1'b0;
  logic [31:0] fin = '0;
  logic [31:0] out_u, out_s;
  logic [7:0]  out_8;
  logic        valid_u, valid_s, valid_8, sat_u, sat_s, sat_8;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fp_to_int #(.INT_WIDTH(32), .INT_UNSIGNED(1'b1), .FP_WIDTH(32)) du (
    .clk(clk), .rst(rst), .in(fin), .ready(ready), .out(out_u), .valid(valid_u), .sat(sat_u));
  fp_to_int #(.INT_WIDTH(32), .INT_UNSIGNED(1'b0), .FP_WIDTH(32)) ds (
    .clk(clk), .rst(rst), .in(fin), .ready(ready), .out(out_s), .valid(valid_s), .sat(sat_s));
  fp_to_int #(.INT_WIDTH(8), .INT_UNSIGNED(1'b0), .FP_WIDTH(32)) d8 (
    .clk(clk), .rst(rst), .in(fin), .ready(ready), .out(out_8), .valid(valid_8), .sat(sat_8));

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] eu;
    logic        su;
    logic [31:0] es;
    logic        ss;
    logic [7:0]  e8;
    logic        s8;
  } vec_t;

  vec_t tbl [0:20];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] enc(input real t, input int w);
    logic [63:0] v;
    v = 64'(longint'(t));
    return (w >= 64) ? v : v & ((64'd1 << w) - 64'd1);
  endfunction

  // real-valued reference: truncate toward zero, then clamp to the integer range
  function automatic logic [64:0] model(input logic [31:0] x, input int w, input bit uns);
    real r, t, lo, hi;
    int  e;
    e  = int'(x[30:23]);
    lo = uns ? 0.0 : -$pow(2.0, real'(w - 1));
    hi = uns ? $pow(2.0, real'(w)) - 1.0 : $pow(2.0, real'(w - 1)) - 1.0;
    if (e == 255) return (x[22:0] != 0) ? {1'b1, 64'd0} : {1'b1, enc(x[31] ? lo : hi, w)};
    r = (e == 0) ? 0.0 : (1.0 + real'(x[22:0]) / 8388608.0) * $pow(2.0, real'(e - 127));
    t = $floor(r);
    if (x[31]) t = -t;
    if (t > hi) return {1'b1, enc(hi, w)};
    if (t < lo) return {1'b1, enc(lo, w)};
    return {1'b0, enc(t, w)};
  endfunction

  task automatic convert(input logic [31:0] x);
    int n;
    n = 0;
    @(negedge clk);
    fin = x;
    ready = 1'b1;
    @(posedge clk);
    #1 ready = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      if (valid_u && valid_s && valid_8) begin
        n = i;
        break;
      end
    end
    chk($sformatf("latency_%h", x), 64'(n), 64'd3);
  endtask

  task automatic check_model(input logic [31:0] x);
    logic [64:0] r;
    r = model(x, 32, 1'b1);
    chk($sformatf("u32_out_%h", x), 64'(out_u), r[63:0]);
    chk($sformatf("u32_sat_%h", x), 64'(sat_u), 64'(r[64]));
    r = model(x, 32, 1'b0);
    chk($sformatf("s32_out_%h", x), 64'(out_s), r[63:0]);
    chk($sformatf("s32_sat_%h", x), 64'(sat_s), 64'(r[64]));
    r = model(x, 8, 1'b0);
    chk($sformatf("s8_out_%h", x), 64'(out_8), r[63:0]);
    chk($sformatf("s8_sat_%h", x), 64'(sat_8), 64'(r[64]));
  endtask

  initial begin
    int vc;
    int pos [4];
    logic [31:0] x;
    tbl = '{
      '{32'h3F800000, 32'd1,          1'b0, 32'd1,          1'b0, 8'h01, 1'b0},
      '{32'h42140000, 32'd37,         1'b0, 32'd37,         1'b0, 8'h25, 1'b0},
      '{32'h45800000, 32'd4096,       1'b0, 32'd4096,       1'b0, 8'h7F, 1'b1},
      '{32'h40300000, 32'd2,          1'b0, 32'd2,          1'b0, 8'h02, 1'b0},
      '{32'h4F7FFFFF, 32'hFFFFFF00,   1'b0, 32'h7FFFFFFF,   1'b1, 8'h7F, 1'b1},
      '{32'h4F800000, 32'hFFFFFFFF,   1'b1, 32'h7FFFFFFF,   1'b1, 8'h7F, 1'b1},
      '{32'hBF800000, 32'd0,          1'b1, 32'hFFFFFFFF,   1'b0, 8'hFF, 1'b0},
      '{32'h7FC00000, 32'd0,          1'b1, 32'd0,          1'b1, 8'h00, 1'b1},
      '{32'h80000000, 32'd0,          1'b0, 32'd0,          1'b0, 8'h00, 1'b0},
      '{32'hCF000000, 32'd0,          1'b1, 32'h80000000,   1'b0, 8'h80, 1'b1},
      '{32'hCF000001, 32'd0,          1'b1, 32'h80000000,   1'b1, 8'h80, 1'b1},
      '{32'h4F000000, 32'h80000000,   1'b0, 32'h7FFFFFFF,   1'b1, 8'h7F, 1'b1},
      '{32'hFF800000, 32'd0,          1'b1, 32'h80000000,   1'b1, 8'h80, 1'b1},
      '{32'h7F800000, 32'hFFFFFFFF,   1'b1, 32'h7FFFFFFF,   1'b1, 8'h7F, 1'b1},
      '{32'hBF000000, 32'd0,          1'b0, 32'd0,          1'b0, 8'h00, 1'b0},
      '{32'h00000001, 32'd0,          1'b0, 32'd0,          1'b0, 8'h00, 1'b0},
      '{32'hC2140000, 32'd0,          1'b1, 32'hFFFFFFDB,   1'b0, 8'hDB, 1'b0},
      '{32'hC3000000, 32'd0,          1'b1, 32'hFFFFFF80,   1'b0, 8'h80, 1'b0},
      '{32'h43000000, 32'd128,        1'b0, 32'd128,        1'b0, 8'h7F, 1'b1},
      '{32'hC3010000, 32'd0,          1'b1, 32'hFFFFFF7F,   1'b0, 8'h80, 1'b1},
      '{32'h42FE0000, 32'd127,        1'b0, 32'd127,        1'b0, 8'h7F, 1'b0}
    };
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", {out_u, out_s}, 64'd0);
    chk("rst_valid", 64'({valid_u, valid_s, valid_8}), 64'd0);
    chk("rst_sat", 64'({sat_u, sat_s, sat_8}), 64'd0);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("idle_%0d", i), {31'd0, valid_u | valid_s | valid_8, out_u}, 64'd0);
    end
    for (int i = 0; i < 21; i++) begin
      convert(tbl[i].x);
      chk($sformatf("tbl%0d_u_out", i), 64'(out_u), 64'(tbl[i].eu));
      chk($sformatf("tbl%0d_u_sat", i), 64'(sat_u), 64'(tbl[i].su));
      chk($sformatf("tbl%0d_s_out", i), 64'(out_s), 64'(tbl[i].es));
      chk($sformatf("tbl%0d_s_sat", i), 64'(sat_s), 64'(tbl[i].ss));
      chk($sformatf("tbl%0d_8_out", i), 64'(out_8), 64'(tbl[i].e8));
      chk($sformatf("tbl%0d_8_sat", i), 64'(sat_8), 64'(tbl[i].s8));
    end
    for (int i = 0; i < 150; i++) begin
      x = (i % 8 == 7) ? 32'($urandom)
                       : {1'($urandom), 8'($urandom_range(110, 165)), 23'($urandom)};
      convert(x);
      check_model(x);
    end
    vc = 0;
    pos = '{-1, -1, -1, -1};
    @(negedge clk);
    fin = 32'h41200000;
    ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (i == 11) ready = 1'b0;
      if (valid_s) begin
        if (vc < 4) pos[vc] = i;
        vc++;
      end
    end
    repeat (6) begin
      @(posedge clk);
      #1;
      if (valid_s) vc++;
    end
    chk("held_count", 64'(vc), 64'd3);
    chk("held_pos0", 64'(pos[0]), 64'd3);
    chk("held_pos1", 64'(pos[1]), 64'd7);
    chk("held_pos2", 64'(pos[2]), 64'd11);
    chk("held_out", {out_u, out_s}, {32'd10, 32'd10});
    convert(32'h3F800000);
    chk("pre_align_out", 64'(out_s), 64'd1);
    vc = 0;
    @(negedge clk);
    fin = 32'h41200000;
    ready = 1'b1;
    @(posedge clk);
    #1 ready = 1'b0;
    fin = 32'h3F800000;
    @(posedge clk);
    #1 ready = 1'b1;
    @(posedge clk);
    #1 ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (valid_s) vc++;
    end
    chk("align_ready_count", 64'(vc), 64'd1);
    chk("align_ready_out", 64'(out_s), 64'd10);
    vc = 0;
    @(negedge clk);
    fin = 32'h42140000;
    ready = 1'b1;
    @(posedge clk);
    #1 ready = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    chk("abort_out", {out_u, out_s}, 64'd0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (valid_u || valid_s || valid_8) vc++;
    end
    chk("abort_valid", 64'(vc), 64'd0);
    chk("abort_out_after", {out_u, out_s}, 64'd0);
    convert(32'h3F800000);
    chk("post_abort_out", {out_u, out_s}, {32'd1, 32'd1});
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
